// File: rtl/adder_seq.sv
// Digit-serial add/subtract: WIDTH-bit operands, DIGIT bits per clock, LSB digit first.
// Define ADDER_SEQ_OVF_EN to add the signed-overflow output ovf.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef ADDER_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   sum
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("adder_seq: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d, carry_q, carry_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       b_eff;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   msb_cin;

  // Operands shift right one digit per cycle, so the active digit is always the
  // low slice; the result fills from the top and ends LSB-aligned after N shifts.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    b_eff   = sub_q ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_eff} + (DIGIT+1)'(carry_q);
    msb_cin = a_q[DIGIT-1] ^ b_eff[DIGIT-1] ^ dsum[DIGIT-1];
    res_cat = {dsum[DIGIT-1:0], res_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dsum[DIGIT];
        if (cnt_q == LAST) begin
          sum_d   = {dsum[DIGIT], res_cat[WIDTH+DIGIT-1:DIGIT]};
          ovf_d   = msb_cin ^ dsum[DIGIT];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
`ifdef ADDER_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: directed plan cases, random ops against an
// arithmetic reference, and DIGIT=1 / DIGIT=16 latency checks on extra instances.
module tb_adder_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, busy1, done1, busy16, done16;
  logic [W:0]   sum, sum1, sum16;
`ifdef ADDER_SEQ_OVF_EN
  logic         ovf, ovf1, ovf16;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_seq #(.WIDTH(W), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done),
`ifdef ADDER_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .sum(sum));

  adder_seq #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1),
`ifdef ADDER_SEQ_OVF_EN
    .ovf(ovf1),
`endif
    .sum(sum1));

  adder_seq #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy16), .done(done16),
`ifdef ADDER_SEQ_OVF_EN
    .ovf(ovf16),
`endif
    .sum(sum16));

  function automatic logic [W:0] model_sum(input logic [W-1:0] x, y, input logic s);
    int unsigned r;
    r = 32'(x) + (s ? 32'(16'hFFFF - y) : 32'(y)) + 32'(s);
    return r[W:0];
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, y, input logic s);
    int sr;
    sr = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    return (sr > 32767) || (sr < -32768);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] ai, bi, input logic si);
    @(negedge clk);
    a = ai; b = bi; sub = si; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded), plus cycles in which busy was high.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    while (edges < 64) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, bi, input logic si,
                        input logic [W:0] exp);
    int e, bc;
    launch(ai, bi, si);
    wait_done(e, bc);
    check({tag, " latency"}, e, 4);
    check({tag, " busy_cycles"}, bc, 4);
    check({tag, " sum"}, sum, exp);
`ifdef ADDER_SEQ_OVF_EN
    check({tag, " ovf"}, ovf, model_ovf(ai, bi, si));
`endif
    @(posedge clk); #1;
    check({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int e, bc, e1, e16, seen;
    logic [W-1:0] ra, rb;
    logic rs;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sum", sum, '0);
`ifdef ADDER_SEQ_OVF_EN
    check("reset ovf", ovf, 1'b0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed plan cases
    run_op("add 5+28", 16'd5, 16'd28, 1'b0, 17'h00021);
    run_op("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    run_op("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 17'h08000);
    run_op("sub 30-15", 16'd30, 16'd15, 1'b1, 17'h1000F);
    run_op("sub 15-30", 16'd15, 16'd30, 1'b1, 17'h0FFF1);
    run_op("sub 0-0", 16'd0, 16'd0, 1'b1, 17'h10000);

    // Start during RUN is ignored; start in the done cycle is accepted
    launch(16'd5, 16'd28, 1'b0);
    @(posedge clk); #1;
    a = 16'd1; b = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(e, bc);
    check("ignored start latency", e, 2);
    check("ignored start sum", sum, 17'd33);
    a = 16'd1; b = 16'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done-cycle start busy", busy, 1'b1);
    check("done-cycle start sum held", sum, 17'd33);
    check("done-cycle start no done", done, 1'b0);
    wait_done(e, bc);
    check("done-cycle start latency", e, 4);
    check("done-cycle start sum", sum, 17'd2);

    // Asynchronous reset mid-RUN
    launch(16'd100, 16'd200, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset done", done, 1'b0);
    check("async reset sum", sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no done after abort", seen, 0);
    run_op("after reset", 16'd100, 16'd200, 1'b0, 17'd300);

    // Random operations against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op("random", ra, rb, rs, model_sum(ra, rb, rs));
    end

    // DIGIT=1 and DIGIT=16 instances from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'd30, 16'd15, 1'b0);
    e1 = 0;
    e16 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done1 && e1 == 0) e1 = k;
      if (done16 && e16 == 0) e16 = k;
    end
    check("digit1 latency", e1, 16);
    check("digit1 sum", sum1, 17'd45);
    check("digit16 latency", e16, 1);
    check("digit16 sum", sum16, 17'd45);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised, multi-cycle successor to the 6-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a ripple carry held in a flop between digits.
- Uses a start/busy/done handshake; the result is registered and held.
- Sits in the datapath where a narrow, area-cheap adder is preferred over a wide combinational one.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 gives a bit-serial adder, DIGIT == WIDTH gives a single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0: a+b; 1: a-b; latched on accepted start.
- a  input  WIDTH  operand A, unsigned/two's complement; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum is updated.
- sum  output  WIDTH+1  result; sum[WIDTH] is the carry-out.

Behaviour:
- N = WIDTH/DIGIT. Elaboration fails (generate-time error) if WIDTH % DIGIT != 0 or DIGIT < 1.
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, internal operand/carry/counter registers=0. Reset asserted mid-operation aborts it; no done is issued and sum reads 0.
- States: IDLE, RUN.
- IDLE, start=1 at an edge:
  - Latch a, b, sub.
  - Carry flop = sub.
  - Digit counter = 0.
  - Go to RUN; busy=1 from the following cycle.
- IDLE, start=0: hold; sum keeps its last value.
- RUN, each edge:
  - Compute digit d = a[d] + (sub ? ~b[d] : b[d]) + carry, where a[d] and b[d] are the current DIGIT-bit slices.
  - Write the low DIGIT bits into the internal result shift register; the new carry goes to the carry flop.
  - Counter increments.
- RUN, edge processing digit N-1:
  - sum <= {final carry, assembled result}.
  - done=1 for exactly this following cycle.
  - busy=0; state=IDLE.
- Latency: done is high in the cycle starting N rising edges after the edge that accepted start. Back-to-back throughput is one operation per N+1 cycles minimum.
- sum changes only on completion or reset. Intermediate digits are never visible on sum.
- start while busy=1: ignored, no queuing. Operand/sub changes while busy: no effect.
- start=1 in the cycle where done=1: state is IDLE, so it is accepted. The new operation begins; sum holds the just-completed result until the next completion.
- Subtraction: sum = a + ~b + 1 mod 2^(WIDTH+1) carry semantics. sum[WIDTH]=1 means no borrow (a >= b unsigned).
- Wrap-around: the digit counter saturates at N-1 only inside RUN and is reset to 0 on every accepted start.

Optional Feature:
- Macro ADDER_SEQ_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0.
  - Updated together with sum on completion.
  - ovf=1 when the signed two's-complement result overflows: carry into MSB XOR carry out of MSB, computed in the last digit.
  - Held until the next completion.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, DIGIT=4: start with a=5, b=28, sub=0 -> busy high for 4 cycles; done pulses once exactly 4 edges after the start edge; sum=0x00021 (33).
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x10000 (carry-out set). With ADDER_SEQ_OVF_EN, ovf=0. With a=0x7FFF, b=1: ovf=1, sum=0x08000.
- sub=1, a=30, b=15 -> sum=0x1000F. sub=1, a=15, b=30 -> sum=0x0FFF1 (sum[16]=0 indicates borrow).
- start pulsed with a=1, b=1 during the 2nd RUN cycle of an a=5, b=28 operation -> ignored; single done, sum=33. Then start asserted in the done cycle with a=1, b=1 -> accepted; next done gives sum=2.
- rst_n driven low asynchronously mid-RUN (between edges) -> busy, done and sum go to 0 immediately; no done after release; a new start then completes normally.
- Reparametrise DIGIT=1 and DIGIT=16 (WIDTH=16): a=30, b=15 -> sum=45, with latency 16 and 1 edges respectively.
